// File: rtl/cpu_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_stack_pkg
//  Description : Shared definitions for the CPU call/return stack sequencer:
//                FSM state encodings and default stack geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_stack_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_PUSH_HI = 3'd1;
    localparam logic [STATE_W-1:0] ST_PUSH_LO = 3'd2;
    localparam logic [STATE_W-1:0] ST_POP_LO  = 3'd3;
    localparam logic [STATE_W-1:0] ST_POP_HI  = 3'd4;
    localparam logic [STATE_W-1:0] ST_BRANCH  = 3'd5;

    localparam logic [15:0] DEFAULT_STACK_BASE = 16'h0100;
    localparam logic [7:0]  DEFAULT_SP_RESET   = 8'hFF;

    // Byte address inside the stack page; the offset is already reduced
    // modulo 256 by the caller, so the page base is never carried into.
    function automatic logic [15:0] stack_addr(input logic [15:0] base,
                                               input logic [7:0]  offset);
        return base + {8'h00, offset};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_stack_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_stack_seq
//  Description : Call/return stack sequencer. A call pushes the 16-bit return
//                address (high byte first) onto a downward-growing byte stack
//                and then branches to the call target; a return pops the low
//                byte then the high byte and branches to the restored PC.
//  Revision    : 1.0  initial release
//
//  Configuration macro:
//    CPU_STACK_BOUNDS_CHECK_EN - when defined, calls that would overflow
//                                (sp < 2) and returns that would underflow
//                                (sp > SP_RESET-2) are refused and flagged
//                                in stack_err. When undefined sp wraps freely.
//
//  Ports:
//    clk          in   1   system clock, rising edge
//    reset        in   1   synchronous active-high reset
//    call_req     in   1   call request pulse (samples ret_pc, call_target)
//    ret_req      in   1   return request pulse
//    ret_pc       in  16   return address to push
//    call_target  in  16   call destination
//    mem_req      out  1   stack memory request
//    mem_we       out  1   stack memory write strobe
//    mem_addr     out 16   stack memory byte address
//    mem_wdata    out  8   stack memory write byte
//    mem_rdata    in   8   stack memory read byte
//    mem_ack      in   1   transfer complete
//    branch       out  1   one-cycle PC load pulse
//    branch_pc    out 16   PC load value, valid while branch=1
//    sp           out  8   current stack pointer
//    busy         out  1   sequencer not idle
//    stack_err    out  1   sticky conflict / bounds error
// ============================================================================
module cpu_stack_seq
    import cpu_stack_pkg::*;
#(
    parameter logic [15:0] STACK_BASE = DEFAULT_STACK_BASE,
    parameter logic [7:0]  SP_RESET   = DEFAULT_SP_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [15:0] ret_pc,
    input  logic [15:0] call_target,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        branch,
    output logic [15:0] branch_pc,
    output logic [7:0]  sp,
    output logic        busy,
    output logic        stack_err
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state;
    logic [7:0]         r_sp;
    logic [7:0]         w_sp;
    logic [15:0]        r_ret_pc;
    logic [15:0]        w_ret_pc;
    logic [15:0]        r_target;
    logic [15:0]        w_target;
    logic [7:0]         r_lo;
    logic [7:0]         w_lo;
    logic [15:0]        r_branch_pc;
    logic [15:0]        w_branch_pc;
    logic               r_err;
    logic               w_err;

    logic               w_is_push;
    logic               w_is_pop;
    logic [7:0]         w_offset;
    logic               w_call_oob;
    logic               w_ret_oob;

`ifdef CPU_STACK_BOUNDS_CHECK_EN
    // A call needs two free bytes below sp; a return needs two pushed bytes
    // above it. The return test is done in 9 bits so a small SP_RESET
    // cannot underflow the comparison.
    assign w_call_oob = (r_sp < 8'd2);
    assign w_ret_oob  = (({1'b0, r_sp} + 9'd2) > {1'b0, SP_RESET});
`else
    assign w_call_oob = 1'b0;
    assign w_ret_oob  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state     = r_state;
        w_sp        = r_sp;
        w_ret_pc    = r_ret_pc;
        w_target    = r_target;
        w_lo        = r_lo;
        w_branch_pc = r_branch_pc;
        w_err       = r_err;

        case (r_state)
            ST_IDLE: begin
                if (call_req && ret_req) begin
                    w_err = 1'b1;
                end else if (call_req) begin
                    if (w_call_oob) begin
                        w_err = 1'b1;
                    end else begin
                        w_ret_pc = ret_pc;
                        w_target = call_target;
                        w_state  = ST_PUSH_HI;
                    end
                end else if (ret_req) begin
                    if (w_ret_oob) begin
                        w_err = 1'b1;
                    end else begin
                        w_state = ST_POP_LO;
                    end
                end
            end
            ST_PUSH_HI: begin
                if (mem_ack) begin
                    w_sp    = r_sp - 8'd1;
                    w_state = ST_PUSH_LO;
                end
            end
            ST_PUSH_LO: begin
                if (mem_ack) begin
                    w_sp        = r_sp - 8'd1;
                    w_branch_pc = r_target;
                    w_state     = ST_BRANCH;
                end
            end
            ST_POP_LO: begin
                if (mem_ack) begin
                    w_lo    = mem_rdata;
                    w_sp    = r_sp + 8'd1;
                    w_state = ST_POP_HI;
                end
            end
            ST_POP_HI: begin
                if (mem_ack) begin
                    w_sp        = r_sp + 8'd1;
                    w_branch_pc = {mem_rdata, r_lo};
                    w_state     = ST_BRANCH;
                end
            end
            ST_BRANCH: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sp        <= SP_RESET;
            r_ret_pc    <= 16'h0000;
            r_target    <= 16'h0000;
            r_lo        <= 8'h00;
            r_branch_pc <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sp        <= w_sp;
            r_ret_pc    <= w_ret_pc;
            r_target    <= w_target;
            r_lo        <= w_lo;
            r_branch_pc <= w_branch_pc;
            r_err       <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Memory interface. sp only moves on mem_ack, so address and data are
    // inherently stable for as long as a transfer is waiting.
    // ------------------------------------------------------------------
    assign w_is_push = (r_state == ST_PUSH_HI) || (r_state == ST_PUSH_LO);
    assign w_is_pop  = (r_state == ST_POP_LO)  || (r_state == ST_POP_HI);

    // Pops address the byte above sp; the 8-bit add wraps inside the page.
    assign w_offset  = w_is_pop ? (r_sp + 8'd1) : r_sp;

    assign mem_req   = w_is_push || w_is_pop;
    assign mem_we    = w_is_push;
    assign mem_addr  = mem_req ? stack_addr(STACK_BASE, w_offset) : 16'h0000;
    assign mem_wdata = (r_state == ST_PUSH_HI) ? r_ret_pc[15:8] :
                       (r_state == ST_PUSH_LO) ? r_ret_pc[7:0]  : 8'h00;

    assign branch    = (r_state == ST_BRANCH);
    assign branch_pc = r_branch_pc;
    assign sp        = r_sp;
    assign busy      = (r_state != ST_IDLE);
    assign stack_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_stack_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_stack_seq
//  Description : Self-checking bench for cpu_stack_seq. A vector table drives
//                calls and returns with varying memory latency; expected
//                memory transfers and branches are queued when each request
//                is driven and compared as the DUT produces them. Short
//                hand-written sequences cover conflicts, ignored requests,
//                stray acks and reset in mid-operation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_stack_seq;

    localparam logic [1:0]  K_WR = 2'd0;
    localparam logic [1:0]  K_RD = 2'd1;
    localparam logic [1:0]  K_BR = 2'd2;
    localparam logic [15:0] BASE = 16'h0100;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        is_call;
        logic [15:0] pc;
        logic [15:0] tgt;
        int          dly;
        logic [15:0] bpc;
        logic [7:0]  sp;
        int          lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        call_req;
    logic        ret_req;
    logic [15:0] ret_pc;
    logic [15:0] call_target;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        branch;
    logic [15:0] branch_pc;
    logic [7:0]  sp;
    logic        busy;
    logic        stack_err;

    logic [7:0]  mem [0:65535];
    logic        force_ack;
    int          ack_delay;
    int          wait_cnt;
    int          cyc;
    int          pass_cnt;
    int          total_cnt;
    logic [7:0]  msp;
    exp_t        exp_q[$];
    vec_t        vecs[6];

    cpu_stack_seq dut (
        .clk         (clk),
        .reset       (reset),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .ret_pc      (ret_pc),
        .call_target (call_target),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .branch      (branch),
        .branch_pc   (branch_pc),
        .sp          (sp),
        .busy        (busy),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack after ack_delay waiting cycles, or tied high.
    initial wait_cnt = 0;
    always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    assign mem_ack   = force_ack || (mem_req && (wait_cnt == ack_delay));
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        exp_t        e;
        logic        prev_wait;
        logic [15:0] p_addr;
        logic        p_we;
        logic [7:0]  p_wdata;
        mem[16'h0100] = 8'h77;
        mem[16'h0101] = 8'h66;
        prev_wait = 1'b0;
        p_addr = '0;
        p_we = 1'b0;
        p_wdata = '0;
        forever begin
            @(negedge clk);
            if (prev_wait && mem_req) begin
                check("hold_addr", 32'(mem_addr), 32'(p_addr));
                check("hold_we", 32'(mem_we), 32'(p_we));
                check("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
            end
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL xfer_unexpected: got we=%0d addr=0x%04h expected no transfer", mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_kind", 32'(mem_we ? K_WR : K_RD), 32'(e.kind));
                    check("xfer_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.kind == K_WR) check("xfer_wdata", 32'(mem_wdata), 32'(e.data[7:0]));
                end
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
            if (branch) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL branch_unexpected: got branch_pc=0x%04h expected no branch", branch_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("branch_kind", 32'(K_BR), 32'(e.kind));
                    check("branch_pc", 32'(branch_pc), 32'(e.data));
                end
            end
            prev_wait = mem_req && !mem_ack;
            p_addr    = mem_addr;
            p_we      = mem_we;
            p_wdata   = mem_wdata;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic is_call, input logic [15:0] pc, input logic [15:0] bpc);
        logic [7:0] o;
        if (is_call) begin
            exp_q.push_back('{K_WR, BASE + {8'h00, msp}, {8'h00, pc[15:8]}});
            msp = msp - 8'd1;
            exp_q.push_back('{K_WR, BASE + {8'h00, msp}, {8'h00, pc[7:0]}});
            msp = msp - 8'd1;
        end else begin
            o = msp + 8'd1;
            exp_q.push_back('{K_RD, BASE + {8'h00, o}, 16'h0000});
            msp = o;
            o = msp + 8'd1;
            exp_q.push_back('{K_RD, BASE + {8'h00, o}, 16'h0000});
            msp = o;
        end
        exp_q.push_back('{K_BR, 16'h0000, bpc});
    endtask

    // Called at the negedge of cycle t0+1; waits (bounded) for branch.
    task automatic wait_branch(input int t0, output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (branch) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("idle_after_branch", 32'(busy), 0);
    endtask

    task automatic run_op(input logic is_call, input logic [15:0] pc, input logic [15:0] tgt,
                          input logic [15:0] bpc, input int dly, output int lat, output int busy_n);
        int t0;
        ack_delay = dly;
        force_ack = (dly == 0);
        push_exp(is_call, pc, bpc);
        call_req = is_call;
        ret_req = !is_call;
        ret_pc = pc;
        call_target = tgt;
        t0 = cyc;
        @(negedge clk);
        call_req = 1'b0;
        ret_req = 1'b0;
        wait_branch(t0, lat, busy_n);
        force_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        call_req = 1'b0;
        ret_req = 1'b0;
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        msp = 8'hFF;
    endtask

    initial begin
        int lat;
        int bn;
        int t0;
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b1;
        call_req = 1'b0;
        ret_req = 1'b0;
        ret_pc = '0;
        call_target = '0;
        force_ack = 1'b0;
        ack_delay = 0;
        msp = 8'hFF;

        vecs[0] = '{1'b1, 16'h1234, 16'h0456, 0, 16'h0456, 8'hFD, 3};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 0, 16'h1234, 8'hFF, 3};
        vecs[2] = '{1'b1, 16'hABCD, 16'h2000, 3, 16'h2000, 8'hFD, 9};
        vecs[3] = '{1'b1, 16'h5678, 16'h3000, 1, 16'h3000, 8'hFB, 5};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 2, 16'h5678, 8'hFD, 7};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 0, 16'hABCD, 8'hFF, 3};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_sp", 32'(sp), 'hFF);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(stack_err), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_branch", 32'(branch), 0);
        check("rst_branch_pc", 32'(branch_pc), 0);

        // Stray acks while idle change nothing
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ack_sp", 32'(sp), 'hFF);
        check("idle_ack_busy", 32'(busy), 0);
        check("idle_ack_mem_req", 32'(mem_req), 0);
        force_ack = 1'b0;

        // Table-driven calls and returns
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].is_call, vecs[i].pc, vecs[i].tgt, vecs[i].bpc, vecs[i].dly, lat, bn);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'(vecs[i].lat));
            check($sformatf("v%0d_sp", i), 32'(sp), 32'(vecs[i].sp));
            check($sformatf("v%0d_err", i), 32'(stack_err), 0);
            check($sformatf("v%0d_queue_drained", i), 32'(exp_q.size()), 0);
        end

        // Requests while busy are ignored without error
        ack_delay = 1;
        push_exp(1'b1, 16'h4321, 16'h0500);
        call_req = 1'b1;
        ret_pc = 16'h4321;
        call_target = 16'h0500;
        t0 = cyc;
        @(negedge clk);
        call_req = 1'b0;
        ret_req = 1'b1;
        @(negedge clk);
        ret_req = 1'b0;
        call_req = 1'b1;
        ret_pc = 16'hFFFF;
        call_target = 16'hFFFF;
        @(negedge clk);
        call_req = 1'b0;
        wait_branch(t0, lat, bn);
        check("busy_ign_latency", 32'(lat), 5);
        check("busy_ign_err", 32'(stack_err), 0);
        check("busy_ign_sp", 32'(sp), 'hFD);
        run_op(1'b0, 16'h0000, 16'h0000, 16'h4321, 0, lat, bn);
        check("busy_ign_ret_sp", 32'(sp), 'hFF);
        check("busy_ign_queue", 32'(exp_q.size()), 0);

        // Simultaneous call and return: sticky error, no operation
        force_ack = 1'b1;
        call_req = 1'b1;
        ret_req = 1'b1;
        ret_pc = 16'h1111;
        call_target = 16'h2222;
        @(negedge clk);
        call_req = 1'b0;
        ret_req = 1'b0;
        check("conflict_err", 32'(stack_err), 1);
        check("conflict_busy", 32'(busy), 0);
        check("conflict_mem_req", 32'(mem_req), 0);
        @(negedge clk);
        check("conflict_err_sticky", 32'(stack_err), 1);
        check("conflict_sp", 32'(sp), 'hFF);
        force_ack = 1'b0;
        do_reset();
        check("err_cleared_by_reset", 32'(stack_err), 0);

        // Return straight after reset
`ifdef CPU_STACK_BOUNDS_CHECK_EN
        force_ack = 1'b1;
        ret_req = 1'b1;
        @(negedge clk);
        ret_req = 1'b0;
        check("underflow_err", 32'(stack_err), 1);
        check("underflow_busy", 32'(busy), 0);
        check("underflow_mem_req", 32'(mem_req), 0);
        @(negedge clk);
        check("underflow_branch", 32'(branch), 0);
        check("underflow_sp", 32'(sp), 'hFF);
        force_ack = 1'b0;
`else
        run_op(1'b0, 16'h0000, 16'h0000, 16'h6677, 0, lat, bn);
        check("wrap_ret_latency", 32'(lat), 3);
        check("wrap_ret_sp", 32'(sp), 'h01);
        check("wrap_ret_err", 32'(stack_err), 0);
        check("wrap_ret_queue", 32'(exp_q.size()), 0);
`endif

        // Reset while waiting in PUSH_LO
        do_reset();
        ack_delay = 3;
        push_exp(1'b1, 16'hBEEF, 16'h0777);
        call_req = 1'b1;
        ret_pc = 16'hBEEF;
        call_target = 16'h0777;
        @(negedge clk);
        call_req = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_push_lo_we", 32'(mem_we), 1);
        check("mid_push_lo_addr", 32'(mem_addr), 'h01FE);
        check("mid_push_lo_wdata", 32'(mem_wdata), 'hEF);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sp", 32'(sp), 'hFF);
        check("mid_rst_mem_req", 32'(mem_req), 0);
        check("mid_rst_branch", 32'(branch), 0);
        check("mid_rst_branch_pc", 32'(branch_pc), 0);
        reset = 1'b0;
        exp_q.delete();
        msp = 8'hFF;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_stack_seq.md
CPU_STACK_SEQ -- requirements
Module: cpu_stack_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter STACK_BASE, default 16'h0100: byte address of stack page.
REQ-003 Parameter SP_RESET, default 8'hFF: stack pointer value after reset; the stack grows downward.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 call_req / ret_req  input  1 each  one-cycle request pulses from decode.
REQ-007 ret_pc  input  16  return address, sampled with call_req.
REQ-008 call_target  input  16  call destination, sampled with call_req.
REQ-009 mem_req / mem_we  output  1 each  stack memory request and write strobe.
REQ-010 mem_addr  output  16 / mem_wdata  output  8  stack address and write byte.
REQ-011 mem_rdata  input  8 / mem_ack  input  1  read byte and transfer-complete strobe.
REQ-012 branch  output  1  one-cycle pulse feeding the CPU control branch status.
REQ-013 branch_pc  output  16  PC load value, valid while branch=1.
REQ-014 sp  output  8  current stack pointer.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 stack_err  output  1  sticky overflow, underflow or conflict flag.

Function
REQ-017 The FSM SHALL have states IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI and BRANCH.
REQ-018 In IDLE, call_req alone SHALL latch ret_pc and call_target and go to PUSH_HI next cycle.
REQ-019 In IDLE, ret_req alone SHALL go to POP_LO next cycle.
REQ-020 call_req and ret_req together SHALL set stack_err, start no operation and stay in IDLE.
REQ-021 Requests arriving while busy=1 SHALL be ignored, with no error raised.
REQ-022 mem_req SHALL be high combinationally in PUSH_* and POP_* states, and low otherwise.
REQ-023 mem_addr, mem_we and mem_wdata SHALL hold stable until the cycle in which mem_ack=1.
REQ-024 PUSH_HI: addr STACK_BASE+sp, we=1, wdata=ret_pc[15:8]; on ack, sp-=1 and go to PUSH_LO.
REQ-025 PUSH_LO: same address rule, wdata=ret_pc[7:0]; on ack, sp-=1 and go to BRANCH with branch_pc=call_target.
REQ-026 POP_LO: addr STACK_BASE+sp+1, we=0; on ack, capture mem_rdata as the low byte, sp+=1 and go to POP_HI.
REQ-027 POP_HI: same address rule; on ack, capture the high byte, sp+=1 and go to BRANCH with branch_pc={hi,lo}.
REQ-028 BRANCH SHALL assert branch for exactly one cycle, then return to IDLE.
REQ-029 With mem_ack tied high, a request at cycle T SHALL give branch=1 at T+3 and busy=1 for T+1..T+3.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.
REQ-031 The sp+1 address arithmetic SHALL wrap modulo 256 inside the 8-bit page offset.

Reset
REQ-032 Reset SHALL override everything in the same edge, including mid-operation: state=IDLE, sp=SP_RESET, stack_err=0.
REQ-033 Reset SHALL clear the latched PC bytes and drive mem_req=0, branch=0 and branch_pc=0.

Configuration
REQ-034 Macro CPU_STACK_BOUNDS_CHECK_EN SHALL select bounds checking.
REQ-035 With the macro defined, call_req with sp<2 SHALL set stack_err, start no operation and produce no branch.
REQ-036 With the macro defined, ret_req with sp>SP_RESET-2 SHALL set stack_err, start no operation and produce no branch.
REQ-037 Without the macro, sp SHALL wrap freely, bounds are never checked and stack_err reports only the REQ-020 conflict.

Structure
REQ-038 Package cpu_stack_pkg SHALL hold the state encodings and the default STACK_BASE and SP_RESET constants.
REQ-039 The block SHALL be a single module with no sub-modules: one state register and one combinational next-state block.

Verification
REQ-040 Reset, mem_ack=1, call_req with ret_pc=16'h1234, call_target=16'h0456 SHALL produce writes 0x12@0x01FF then 0x34@0x01FE, branch at T+3 with branch_pc=0x0456, then sp=0xFD.
REQ-041 ret_req following REQ-040, with memory returning 0x34 then 0x12, SHALL produce reads at 0x01FE then 0x01FF, branch_pc=0x1234 and sp=0xFF.
REQ-042 mem_ack delayed 3 cycles per transfer SHALL keep the address and data stable while waiting, with branch at T+9.
REQ-043 call_req and ret_req in the same cycle SHALL give stack_err=1, busy=0 and no mem_req.
REQ-044 With the macro defined, ret_req just after reset SHALL give stack_err=1 and no memory traffic; without the macro it SHALL read 0x0100 then 0x0101 and end with sp=0x01.
REQ-045 Reset asserted while in PUSH_LO SHALL give state IDLE, sp=0xFF and mem_req=0 in the next cycle.
